// File: rtl/input_pad_debounce_ctrl.sv
// input_pad_debounce_ctrl: synchronises, debounces and edge-qualifies a bank
// of pull-up input pads into pending flags and a combined interrupt.
// Optional build macro INPUT_PAD_DB_ANY_EDGE_EN adds EDGE_ANY, which lets a
// channel raise pending on both accepted edges.

// Per-channel synchroniser, debounce counter and pending flag.
module input_pad_debounce_lane #(
  parameter int DB_COUNT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic pad_i,
  input  logic edge_sel_i,
  input  logic any_i,
  input  logic en_i,
  input  logic clr_i,
  output logic db_o,
  output logic pend_o
);
  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          accept, edge_ok;

  // Two-flop synchroniser; resets to the idle (pulled-up) level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], pad_i};
  end

  // Debounce on tick; pending set/clear every cycle, set wins over clear.
  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (tick_i) begin
      if (sync_q[1] != db_q) begin
        if (cnt_q == CNT_MAX) begin
          accept = 1'b1;
          db_d   = ~db_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
    // db_q is the level before the accept: 1 means this is a falling edge.
    edge_ok = any_i | (edge_sel_i ? ~db_q : db_q);
    pend_d  = (accept & en_i & edge_ok) | (pend_q & ~clr_i);
  end

  // Debounced level, qualification count and pending flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_q   <= 1'b1;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign db_o   = db_q;
  assign pend_o = pend_q;
endmodule

module input_pad_debounce_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 1000,
  parameter int DB_COUNT = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NUM_CH-1:0] PAD_IN,
  input  logic [NUM_CH-1:0] EDGE_SEL,
  input  logic [NUM_CH-1:0] IRQ_EN,
  input  logic [NUM_CH-1:0] IRQ_CLR,
`ifdef INPUT_PAD_DB_ANY_EDGE_EN
  input  logic [NUM_CH-1:0] EDGE_ANY,
`endif
  output logic [NUM_CH-1:0] DB_OUT,
  output logic [NUM_CH-1:0] IRQ_PEND,
  output logic              IRQ
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [NUM_CH-1:0] any_edge;

`ifdef INPUT_PAD_DB_ANY_EDGE_EN
  assign any_edge = EDGE_ANY;
`else
  assign any_edge = '0;
`endif

  // Shared sample tick: one cycle high at the top of the prescaler count.
  always_comb begin
    tick    = (presc_q == PRE_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    input_pad_debounce_lane #(.DB_COUNT(DB_COUNT)) u_lane (
      .clk_i      (HCLK),
      .rst_i      (HRESET),
      .tick_i     (tick),
      .pad_i      (PAD_IN[i]),
      .edge_sel_i (EDGE_SEL[i]),
      .any_i      (any_edge[i]),
      .en_i       (IRQ_EN[i]),
      .clr_i      (IRQ_CLR[i]),
      .db_o       (DB_OUT[i]),
      .pend_o     (IRQ_PEND[i])
    );
  end

  assign IRQ = |IRQ_PEND;
endmodule

// File: tb/tb_input_pad_debounce_ctrl.sv
// Directed bench for input_pad_debounce_ctrl (PRESCALE=4, DB_COUNT=3, NUM_CH=4).
// Ticking edges fall on every 4th posedge after reset release, so a clean
// step applied right after a ticking edge is accepted exactly 12 edges later.
module tb_input_pad_debounce_ctrl;
  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] PAD_IN, EDGE_SEL, IRQ_EN, IRQ_CLR;
`ifdef INPUT_PAD_DB_ANY_EDGE_EN
  logic [3:0] EDGE_ANY;
`endif
  logic [3:0] DB_OUT, IRQ_PEND;
  logic       IRQ;

  int n_chk = 0, n_fail = 0;
  int ecnt;
  int tog_n[4], tog_at[4];
  logic [3:0] prev_db;
  int k0;

  input_pad_debounce_ctrl #(.NUM_CH(4), .PRESCALE(4), .DB_COUNT(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PAD_IN(PAD_IN), .EDGE_SEL(EDGE_SEL),
    .IRQ_EN(IRQ_EN), .IRQ_CLR(IRQ_CLR),
`ifdef INPUT_PAD_DB_ANY_EDGE_EN
    .EDGE_ANY(EDGE_ANY),
`endif
    .DB_OUT(DB_OUT), .IRQ_PEND(IRQ_PEND), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One posedge, then sample 1 time unit later and log DB_OUT toggles.
  task automatic step();
    @(posedge HCLK); #1;
    ecnt++;
    for (int c = 0; c < 4; c++)
      if (DB_OUT[c] !== prev_db[c]) begin
        tog_n[c]++;
        tog_at[c] = ecnt;
      end
    prev_db = DB_OUT;
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic align();
    while (ecnt % 4 != 0) step();
  endtask

  task automatic clr_tog();
    for (int c = 0; c < 4; c++) begin
      tog_n[c] = 0;
      tog_at[c] = -1;
    end
  endtask

  task automatic pulse_clr(input logic [3:0] m);
    IRQ_CLR = m;
    step();
    IRQ_CLR = 4'b0000;
  endtask

  initial begin
    HRESET = 1'b1; PAD_IN = 4'b0000; EDGE_SEL = 4'b0000;
    IRQ_EN = 4'b0000; IRQ_CLR = 4'b0000;
`ifdef INPUT_PAD_DB_ANY_EDGE_EN
    EDGE_ANY = 4'b0000;
`endif
    // Reset held with pads low: outputs idle.
    for (int j = 0; j < 3; j++) begin
      @(posedge HCLK); #1;
      chk("rst_db", DB_OUT, 4'b1111);
      chk("rst_pend", IRQ_PEND, 4'b0000);
      chk("rst_irq", IRQ, 1'b0);
    end
    PAD_IN = 4'b1111;
    HRESET = 1'b0;
    ecnt = 0; prev_db = DB_OUT; clr_tog();

    // Clean press on ch0, falling edge enabled.
    IRQ_EN = 4'b0001;
    PAD_IN[0] = 1'b0;
    steps(12);
    chk("press_at", tog_at[0], 12);
    chk("press_db", DB_OUT, 4'b1110);
    chk("press_pend", IRQ_PEND, 4'b0001);
    chk("press_irq", IRQ, 1'b1);
    pulse_clr(4'b0001);
    chk("clr_pend", IRQ_PEND, 4'b0000);
    chk("clr_irq", IRQ, 1'b0);

    // Bounce on ch1: low 2 ticks, high 1 tick, low 3 ticks.
    align(); clr_tog(); k0 = ecnt;
    PAD_IN[1] = 1'b0; steps(8);
    PAD_IN[1] = 1'b1; steps(4);
    PAD_IN[1] = 1'b0; steps(16);
    chk("bounce_ntog", tog_n[1], 1);
    chk("bounce_at", tog_at[1] - k0, 24);
    chk("bounce_db", DB_OUT[1], 1'b0);

    // Ch2 rising-edge select, masked then enabled.
    EDGE_SEL[2] = 1'b1;
    align(); clr_tog(); k0 = ecnt;
    PAD_IN[2] = 1'b0; steps(16);
    chk("mask_fall_db", DB_OUT[2], 1'b0);
    chk("mask_fall_pend", IRQ_PEND[2], 1'b0);
    PAD_IN[2] = 1'b1; steps(16);
    chk("mask_rise_db", DB_OUT[2], 1'b1);
    chk("mask_rise_pend", IRQ_PEND[2], 1'b0);
    IRQ_EN[2] = 1'b1;
    PAD_IN[2] = 1'b0; steps(16);
    chk("en_fall_db", DB_OUT[2], 1'b0);
    chk("en_fall_pend", IRQ_PEND[2], 1'b0);
    clr_tog(); k0 = ecnt;
    PAD_IN[2] = 1'b1; steps(11);
    chk("en_rise_early", IRQ_PEND[2], 1'b0);
    step();
    chk("en_rise_at", tog_at[2] - k0, 12);
    chk("en_rise_pend", IRQ_PEND[2], 1'b1);
    pulse_clr(4'b0100);
    chk("en_rise_clr", IRQ_PEND, 4'b0000);

    // Set/clear collision on ch0.
    IRQ_EN = 4'b0001;
    PAD_IN[0] = 1'b1; steps(16);
    chk("rel0_db", DB_OUT[0], 1'b1);
    chk("rel0_pend", IRQ_PEND[0], 1'b0);
    align();
    PAD_IN[0] = 1'b0; steps(11);
    chk("coll_pre", IRQ_PEND[0], 1'b0);
    pulse_clr(4'b0001);
    chk("coll_db", DB_OUT[0], 1'b0);
    chk("coll_pend", IRQ_PEND[0], 1'b1);
    IRQ_EN = 4'b0000; steps(4);
    chk("en_off_keep", IRQ_PEND[0], 1'b1);
    pulse_clr(4'b0001);
    chk("en_off_clr", IRQ_PEND[0], 1'b0);

    // Async reset mid-qualification on ch3, pad held low through reset.
    IRQ_EN = 4'b1000;
    align();
    PAD_IN[3] = 1'b0; steps(6);
    #2 HRESET = 1'b1;
    #1 chk("arst_db", DB_OUT, 4'b1111);
    chk("arst_pend", IRQ_PEND, 4'b0000);
    @(posedge HCLK); #1;
    chk("arst_hold", DB_OUT, 4'b1111);
    HRESET = 1'b0;
    ecnt = 0; prev_db = DB_OUT; clr_tog();
    steps(11);
    chk("requal_early", DB_OUT[3], 1'b1);
    step();
    chk("requal_at", tog_at[3], 12);
    chk("requal_db", DB_OUT, 4'b0100);
    chk("requal_pend", IRQ_PEND, 4'b1000);
    chk("requal_irq", IRQ, 1'b1);
    pulse_clr(4'b1000);
    chk("requal_clr", IRQ_PEND, 4'b0000);

`ifdef INPUT_PAD_DB_ANY_EDGE_EN
    // Both edges on ch0; EDGE_SEL=1 must be ignored.
    EDGE_ANY = 4'b0001; EDGE_SEL[0] = 1'b1; IRQ_EN = 4'b0001;
    align();
    PAD_IN[0] = 1'b1; steps(12);
    chk("any_rise_db", DB_OUT[0], 1'b1);
    chk("any_rise_pend", IRQ_PEND, 4'b0001);
    pulse_clr(4'b0001);
    chk("any_clr", IRQ_PEND, 4'b0000);
    PAD_IN[0] = 1'b0; steps(12);
    chk("any_fall_db", DB_OUT[0], 1'b0);
    chk("any_fall_pend", IRQ_PEND, 4'b0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
